bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that consumes the 32-bit result of the power/exponentiation unit and produces packed decimal digits for the seven-segment display driver. It sits directly downstream of the power unit's result register. A controller pulses `start` once the power unit reaches its final state. One conversion is in flight at a time; each takes a fixed number of cycles.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_add3.sv | 10 +
 rtl/bin_to_bcd.sv | 111 +++++++++++
 tb/tb_bin_to_bcd.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding,
// default sizes and the iteration-counter width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DIGITS = 10;

  // Counter must index 0..w-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: digits of 5 or more get +3 so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per ADJUST/SHIFT pair.
// Optional leading-zero blanking of digit_en when LEADING_ZERO_BLANK_EN is defined.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_t           state;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_shift;
  logic [WIDTH-1:0] bin_sr;
  logic [CW-1:0]    cnt;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_add3 u_add3 (
        .digit    (acc[4*gi +: 4]),
        .adjusted (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign acc_shift = {acc[BW-2:0], bin_sr[WIDTH-1]};

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] en_next;
  logic              seen;

  // Scan from the most significant digit down; once a nonzero digit is
  // seen, every lower digit is lit. Units digit is always lit.
  always_comb begin
    en_next = '0;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (|acc_shift[4*i +: 4]);
      en_next[i] = seen;
    end
    en_next[0] = 1'b1;
  end
`else
  assign digit_en = '1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      bcd    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      digit_en <= '1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ADJUST;
          end
        end
        ADJUST: begin
          acc   <= acc_adj;
          state <= SHIFT;
        end
        SHIFT: begin
          acc    <= acc_shift;
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= acc_shift;
`ifdef LEADING_ZERO_BLANK_EN
            digit_en <= en_next;
`endif
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ADJUST;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed cases plus random values checked
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   bin = '0;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]  digit_en;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .digit_en (digit_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_en(input longint unsigned v);
`ifdef LEADING_ZERO_BLANK_EN
    int n;
    logic [DIGITS-1:0] e;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    e = '0;
    for (int i = 0; i < n; i++) e[i] = 1'b1;
    return e;
`else
    return '1;
`endif
  endfunction

  // Accept a value; returns at the sample point of cycle 1 after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = $urandom;
  endtask

  // Wait for done; cyc = cycle index after acceptance at which done seen (0 on timeout).
  task automatic wait_done(input logic [4*DIGITS-1:0] prev, output int cyc,
                           output int busy_cnt, output bit stable);
    cyc = 0; busy_cnt = 0; stable = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        cyc = n;
        break;
      end
      if (bcd !== prev) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string name, input longint unsigned v, input int cyc);
    checks++;
    if (cyc != 2*WIDTH + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, 2*WIDTH + 1);
    end
    checks++;
    if (bcd !== ref_bcd(v)) begin
      errors++;
      $display("FAIL %s bcd: got %h expected %h", name, bcd, ref_bcd(v));
    end
    checks++;
    if (digit_en !== ref_en(v)) begin
      errors++;
      $display("FAIL %s digit_en: got %h expected %h", name, digit_en, ref_en(v));
    end
    $display("txn %s bin=%0d bcd=%h digit_en=%h cycle=%0d", name, v, bcd, digit_en, cyc);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || digit_en !== '1) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b bcd=%h en=%h expected 0 0 0 3ff",
               busy, done, bcd, digit_en);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset busy=%b done=%b bcd=%h", busy, done, bcd);
  endtask

  task automatic test_zero();
    int cyc, bc; bit st;
    accept(32'd0);
    wait_done(bcd, cyc, bc, st);
    check_result("zero", 0, cyc);
  endtask

  task automatic test_1024();
    int cyc, bc; bit st;
    logic [4*DIGITS-1:0] prev;
    prev = bcd;
    accept(32'd1024);
    wait_done(prev, cyc, bc, st);
    check_result("1024", 1024, cyc);
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL bcd_stable: bcd changed before done, expected %h held", prev);
    end
  endtask

  task automatic test_max();
    int cyc, bc; bit st;
    accept(32'hFFFF_FFFF);
    wait_done(bcd, cyc, bc, st);
    check_result("max", 64'hFFFF_FFFF, cyc);
    checks++;
    if (bc != 2*WIDTH + 1) begin
      errors++;
      $display("FAIL busy_len: got %0d expected %0d", bc, 2*WIDTH + 1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, extra;
    cyc = 0; extra = 0;
    accept(32'd7);
    for (int n = 1; n <= 200; n++) begin
      if (n == 20) begin
        bin   = 32'd99;
        start = 1'b1;
      end else if (n == 21) begin
        start = 1'b0;
      end
      if (done) begin
        cyc = n;
        break;
      end
      @(negedge clk);
    end
    check_result("ignore", 7, cyc);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || bcd !== ref_bcd(7)) begin
      errors++;
      $display("FAIL ignore_second: got extra_done=%0d bcd=%h expected 0 %h",
               extra, bcd, ref_bcd(7));
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bc; bit st;
    accept(32'd4_000_000);
    repeat (29) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0) begin
      errors++;
      $display("FAIL abort: got busy=%b done=%b bcd=%h expected 0 0 0", busy, done, bcd);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_restart: got busy=%b expected 0", busy);
    end
    accept(32'd12345);
    wait_done(bcd, cyc, bc, st);
    check_result("post_reset", 12345, cyc);
  endtask

  task automatic test_back_to_back();
    int stamps[$];
    int first_edge;
    @(negedge clk);
    bin   = 32'd500;
    start = 1'b1;
    first_edge = cycle;
    for (int n = 0; n < 300 && stamps.size() < 3; n++) begin
      @(negedge clk);
      if (done) begin
        stamps.push_back(cycle);
        checks++;
        if (bcd !== ref_bcd(500)) begin
          errors++;
          $display("FAIL b2b_bcd: got %h expected %h", bcd, ref_bcd(500));
        end
        $display("txn b2b done at cycle %0d bcd=%h", cycle, bcd);
      end
    end
    start = 1'b0;
    checks++;
    if (stamps.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses expected 3", stamps.size());
    end else begin
      checks++;
      if (stamps[0] - first_edge != 2*WIDTH + 1) begin
        errors++;
        $display("FAIL b2b_first: got %0d expected %0d", stamps[0] - first_edge, 2*WIDTH + 1);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (stamps[i] - stamps[i-1] != 2*WIDTH + 2) begin
          errors++;
          $display("FAIL b2b_period: got %0d expected %0d", stamps[i] - stamps[i-1], 2*WIDTH + 2);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_random();
    int cyc, bc; bit st;
    logic [WIDTH-1:0] v;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        2: v = $urandom_range(0, 99999);
        default: v = {$urandom} >> $urandom_range(0, 31);
      endcase
      accept(v);
      wait_done(bcd, cyc, bc, st);
      check_result("random", longint'(v), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1024();
    test_max();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
